// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected argmax output stage.
// Holds the FSM state encoding, datapath widths and the product sign-extension helper.
// Used by fc_mac_lane and fc_argmax.
package fc_pkg;

  localparam int FEAT_W    = 6;
  localparam int WGT_W     = 8;
  localparam int PROD_W    = FEAT_W + WGT_W;
  // Widest accumulator the helper can feed; callers truncate to their ACC_W.
  localparam int ACC_MAX_W = 64;

  typedef enum logic [2:0] {
    S_CLR,
    S_ACC,
    S_DRAIN,
    S_MAX,
    S_OUT
  } state_t;

  // Sign-extend a 14-bit signed product; the caller narrows it to its accumulator width.
  function automatic logic signed [ACC_MAX_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_MAX_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One class lane: signed 6x8 multiply feeding a wrapping ACC_W accumulator.
// Latency: product of the current operands lands in o_acc one cycle after i_en.
// No backpressure; i_clr has priority over i_en.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [FEAT_W-1:0] i_feat,
  input  logic signed [WGT_W-1:0]  i_wgt,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_acc;

  // Both operands widened to the full product width so the multiply is exact.
  assign w_prod     = PROD_W'(i_feat) * PROD_W'(i_wgt);
  assign w_prod_ext = ACC_W'(sext_prod(w_prod));

  // Accumulate one product per enabled cycle; wraps modulo 2^ACC_W.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fc_argmax.sv
// FC output stage: N_CLASS parallel MAC lanes over N_FEAT features, then a serial argmax scan.
// Latency: last feature accepted in cycle t gives out_valid in cycle t+2+N_CLASS.
// in_ready only in S_ACC; result held on out_valid/out_score/out_class until out_ready.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int N_FEAT  = 16,
  parameter int N_CLASS = 10,
  parameter int ACC_W   = 20
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       in_valid,
  input  logic [FEAT_W-1:0]          in_feat,
  output logic                       in_ready,
  output logic                       w_rd,
  output logic [$clog2(N_FEAT)-1:0]  w_addr,
  input  logic [WGT_W*N_CLASS-1:0]   w_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_CLASS)-1:0] out_class,
  output logic [ACC_W-1:0]           out_score
);

  localparam int CNT_W = $clog2(N_FEAT);
  localparam int CLS_W = $clog2(N_CLASS);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_feat_cnt;
  logic signed [FEAT_W-1:0]  r_feat;
  logic                      r_mac_en;
  logic [CLS_W-1:0]          r_scan_idx;
  logic [CLS_W-1:0]          r_best_idx;
  logic signed [ACC_W-1:0]   r_best_score;
  logic                      r_in_ready;
  logic                      r_out_valid;

  logic                      w_accept;
  logic                      w_last_feat;
  logic                      w_scan_last;
  logic                      w_clr;
  logic signed [ACC_W-1:0]   w_acc [N_CLASS];
  logic signed [ACC_W-1:0]   w_sel_acc;

  assign w_accept    = in_valid && r_in_ready;
  assign w_last_feat = (r_feat_cnt == CNT_W'(N_FEAT - 1));
  assign w_scan_last = (r_scan_idx == CLS_W'(N_CLASS - 1));
  assign w_clr       = (r_state == S_CLR);
  assign w_sel_acc   = w_acc[r_scan_idx];

  // Weight row fetch is issued in the accept cycle; the row returns alongside r_feat.
  assign w_rd   = w_accept;
  assign w_addr = w_accept ? r_feat_cnt : '0;

  genvar c;
  generate
    for (c = 0; c < N_CLASS; c++) begin : g_lane
      fc_mac_lane #(
        .ACC_W (ACC_W)
      ) u_lane (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_clr  (w_clr),
        .i_en   (r_mac_en),
        .i_feat (r_feat),
        .i_wgt  (w_data[WGT_W*c +: WGT_W]),
        .o_acc  (w_acc[c])
      );
    end
  endgenerate

  // Frame FSM: clear, accumulate, drain the MAC pipe, scan for the max, present result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_CLR;
      r_feat_cnt   <= '0;
      r_feat       <= '0;
      r_mac_en     <= 1'b0;
      r_scan_idx   <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_mac_en <= w_accept;
      if (w_accept) begin
        r_feat <= in_feat;
      end
      case (r_state)
        S_CLR: begin
          r_feat_cnt   <= '0;
          r_scan_idx   <= '0;
          r_best_idx   <= '0;
          r_best_score <= '0;
          r_in_ready   <= 1'b1;
          r_state      <= S_ACC;
        end
        S_ACC: begin
          if (w_accept) begin
            r_feat_cnt <= r_feat_cnt + CNT_W'(1);
            if (w_last_feat) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_scan_idx <= '0;
          r_state    <= S_MAX;
        end
        S_MAX: begin
          // Strict compare keeps the lowest index on ties.
          if ((r_scan_idx == '0) || (w_sel_acc > r_best_score)) begin
            r_best_idx   <= r_scan_idx;
            r_best_score <= w_sel_acc;
          end
          if (w_scan_last) begin
            r_scan_idx  <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_scan_idx <= r_scan_idx + CLS_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_CLR;
          end
        end
        default: begin
          r_state <= S_CLR;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_class = r_best_idx;
  assign out_score = r_best_score;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: directed frames plus randomized frames against a score model.
// Weight ROM is modelled with one-cycle read latency and garbage on idle cycles.
// Checks reset, latency, argmax/tie rules, backpressure, frame gap and async reset mid-frame.
module tb_fc_argmax;

  localparam int N_FEAT  = 16;
  localparam int N_CLASS = 10;
  localparam int ACC_W   = 20;
  localparam int CNT_W   = $clog2(N_FEAT);
  localparam int CLS_W   = $clog2(N_CLASS);

  logic                   CLK = 1'b0;
  logic                   RST_N;
  logic                   in_valid;
  logic [5:0]             in_feat;
  logic                   in_ready;
  logic                   w_rd;
  logic [CNT_W-1:0]       w_addr;
  logic [8*N_CLASS-1:0]   w_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CLS_W-1:0]       out_class;
  logic [ACC_W-1:0]       out_score;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int feat_a [N_FEAT];
  int wrom   [N_FEAT][N_CLASS];

  fc_argmax #(
    .N_FEAT  (N_FEAT),
    .N_CLASS (N_CLASS),
    .ACC_W   (ACC_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_feat   (in_feat),
    .in_ready  (in_ready),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [8*N_CLASS-1:0] rom_row(input int f);
    logic [8*N_CLASS-1:0] r;
    r = '0;
    for (int c = 0; c < N_CLASS; c++) r[8*c +: 8] = 8'(wrom[f][c]);
    return r;
  endfunction

  // Weight ROM: row valid one cycle after the read strobe, junk otherwise.
  always @(posedge CLK) begin
    if (w_rd) w_data <= rom_row(int'(w_addr));
    else      w_data <= (8*N_CLASS)'({$urandom(), $urandom(), $urandom()});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer dot products, then first-maximum search.
  function automatic void model(output int cls, output int score);
    int s [N_CLASS];
    for (int c = 0; c < N_CLASS; c++) begin
      s[c] = 0;
      for (int f = 0; f < N_FEAT; f++) s[c] += feat_a[f] * wrom[f][c];
    end
    cls   = 0;
    score = s[0];
    for (int c = 1; c < N_CLASS; c++) begin
      if (s[c] > score) begin
        cls   = c;
        score = s[c];
      end
    end
  endfunction

  task automatic set_linear();
    for (int f = 0; f < N_FEAT; f++) begin
      feat_a[f] = 1;
      for (int c = 0; c < N_CLASS; c++) wrom[f][c] = c;
    end
  endtask

  task automatic set_extreme();
    for (int f = 0; f < N_FEAT; f++) begin
      feat_a[f] = -32;
      for (int c = 0; c < N_CLASS; c++) wrom[f][c] = (c == 3) ? 127 : -128;
    end
  endtask

  task automatic set_zero_w();
    for (int f = 0; f < N_FEAT; f++) begin
      feat_a[f] = int'($urandom_range(0, 63)) - 32;
      for (int c = 0; c < N_CLASS; c++) wrom[f][c] = 0;
    end
  endtask

  task automatic set_random();
    for (int f = 0; f < N_FEAT; f++) begin
      feat_a[f] = int'($urandom_range(0, 63)) - 32;
      for (int c = 0; c < N_CLASS; c++) wrom[f][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Offer n features starting at index 0; returns the cycle index of the last accept.
  task automatic send_frame(input int n, input bit gaps, output int t_last);
    int i;
    int guard;
    i = 0;
    guard = 0;
    t_last = 0;
    while (i < n && guard < 1000) begin
      @(negedge CLK);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_feat  = 6'($urandom());
        #1;
        check("w_rd_idle", 32'(w_rd), 32'd0);
      end else begin
        in_valid = 1'b1;
        in_feat  = 6'(feat_a[i]);
        #1;
        if (in_ready) begin
          check("w_rd_accept", 32'(w_rd), 32'd1);
          check("w_addr", 32'(w_addr), 32'(i));
          t_last = cyc;
          i++;
        end
      end
    end
    check("features_accepted", 32'(i), 32'(n));
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, check it and its latency, optionally stall, then handshake.
  task automatic finish_frame(input string tag, input int t_last, input bit hold,
                              input int exp_cls, input int exp_score);
    logic [ACC_W-1:0] es;
    int guard;
    es = ACC_W'(exp_score);
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (out_valid !== 1'b1 && guard < 200);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(cyc - t_last), 32'd12);
    check({tag, "_class"}, 32'(out_class), 32'(exp_cls));
    check({tag, "_score"}, 32'(out_score), 32'(es));
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_class"}, 32'(out_class), 32'(exp_cls));
        check({tag, "_hold_score"}, 32'(out_score), 32'(es));
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_clr_ready"}, 32'(in_ready), 32'd0);
    @(negedge CLK);
    check({tag, "_post_acc_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int t;
    int m_cls;
    int m_score;

    RST_N     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge CLK);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_score", 32'(out_score), 32'd0);
    check("rst_w_rd", 32'(w_rd), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);

    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    check("acc_in_ready", 32'(in_ready), 32'd1);

    // Linear weights back-to-back, result stalled for five cycles.
    set_linear();
    send_frame(N_FEAT, 1'b0, t);
    finish_frame("linear", t, 1'b1, 9, 144);

    // Extremes with a tie at the top; out_ready raised before the result exists.
    set_extreme();
    out_ready = 1'b1;
    send_frame(N_FEAT, 1'b0, t);
    finish_frame("extreme", t, 1'b0, 0, 65536);

    // All-zero weights.
    set_zero_w();
    send_frame(N_FEAT, 1'b1, t);
    finish_frame("zero_w", t, 1'b0, 0, 0);

    // Linear again with random input bubbles: same answer as back-to-back.
    set_linear();
    send_frame(N_FEAT, 1'b1, t);
    finish_frame("linear_gaps", t, 1'b0, 9, 144);

    // Random frames against the model.
    for (int r = 0; r < 4; r++) begin
      set_random();
      model(m_cls, m_score);
      send_frame(N_FEAT, r[0], t);
      finish_frame("random", t, 1'b0, m_cls, m_score);
    end

    // Async reset after seven features; partial sums must not leak into the next frame.
    set_linear();
    send_frame(7, 1'b0, t);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_w_rd", 32'(w_rd), 32'd0);
    check("arst_out_class", 32'(out_class), 32'd0);
    check("arst_out_score", 32'(out_score), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    send_frame(N_FEAT, 1'b0, t);
    finish_frame("after_arst", t, 1'b0, 9, 144);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
